// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// the width derivations used by the arbiter and its priority picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int owner_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Burst counter width able to hold values 0..max_burst.
  function automatic int count_bits(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin selector: first set request bit scanning
// ptr, ptr+1, ... wrapping modulo N. Shared with the read-side scheduler.
module rr_priority_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = owner_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between several producers;
// each owner gets a bounded burst, then priority rotates past it.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int Width      = 8,
  parameter  int Requesters = 4,
  parameter  int MaxBurst   = 4,
  localparam int OwnerBits  = owner_bits(Requesters)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [Requesters-1:0]       REQ,
  input  logic [Requesters*Width-1:0] REQdata,
  output logic [Requesters-1:0]       GNT,
  output logic                        WRreq,
  output logic [Width-1:0]            WRdata,
  input  logic                        FIFOfull,
  output logic [OwnerBits-1:0]        Owner,
  output logic                        Busy
);

  localparam int                    CountBits = count_bits(MaxBurst);
  localparam logic [CountBits-1:0]  LastCount = CountBits'(MaxBurst - 1);
  localparam logic [OwnerBits-1:0]  LastOwner = OwnerBits'(Requesters - 1);

  state_t                state_q, state_d;
  logic [OwnerBits-1:0]  ptr_q, ptr_d, owner_d, ptr_after;
  logic [CountBits-1:0]  count_q, count_d;
  logic                  pick_found, owner_req, write_ok;
  logic [OwnerBits-1:0]  pick_idx;

  rr_priority_pick #(
    .N  (Requesters),
    .PW (OwnerBits)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req = REQ[Owner];
  assign WRdata    = REQdata[Owner*Width +: Width];
  // Wrap modulo Requesters, not modulo 2**OwnerBits.
  assign ptr_after = (Owner == LastOwner) ? '0 : Owner + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = Owner;
    count_d  = count_q;
    write_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Release takes priority over a full FIFO.
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = ptr_after;
          count_d = '0;
        end else if (!FIFOfull) begin
          write_ok = 1'b1;
          if (count_q == LastCount) begin
            state_d = IDLE;
            ptr_d   = ptr_after;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so a reset landing mid-burst never writes the FIFO.
  assign WRreq = write_ok & ~reset;

  always_comb begin
    GNT        = '0;
    GNT[Owner] = WRreq;
  end

  assign Busy = (state_q == BURST);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      Owner   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      Owner   <= owner_d;
    end
  end

endmodule
